gshare_counter_table: RTL and testbench

Pattern history table of the gshare branch predictor. It hashes the DEC-stage branch PC with the global history register output and returns a taken/not-taken prediction from a table of 2-bit saturating counters. That prediction is the `i_Prediction` input of the global history register. The block also carries the lookup index down to EX, so the counter that made the prediction is the one trained when the branch resolves.

---
 rtl/bpred_pkg.sv | 17 +
 rtl/bpred_sat_counter.sv | 21 ++
 rtl/gshare_counter_table.sv | 119 +++++++++++
 tb/tb_gshare_counter_table.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types for the gshare predictor: 2-bit counter encoding and the
// table-initialisation state machine states.
package bpred_pkg;

    typedef logic [1:0] bpred_ctr_t;

    localparam bpred_ctr_t CTR_SNT = 2'b00;
    localparam bpred_ctr_t CTR_WNT = 2'b01;
    localparam bpred_ctr_t CTR_WT  = 2'b10;
    localparam bpred_ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } bpred_init_state_t;

endpackage

// File: rtl/bpred_sat_counter.sv
// Next-value function of a 2-bit saturating branch counter.
module bpred_sat_counter
    import bpred_pkg::*;
(
    input  bpred_ctr_t ctr_i,
    input  logic       taken_i,
    output bpred_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST)
                ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT)
                ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_counter_table.sv
// gshare pattern history table with EX-stage training and reset-time sweep.
// Define BPRED_BYPASS_EN to forward a same-index training write to the lookup.
module gshare_counter_table
    import bpred_pkg::*;
#(
    parameter int BPRED_WIDTH = 8,
    parameter int PC_LSB      = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [31:0]            i_DEC_PC,
    input  logic [BPRED_WIDTH-1:0] i_Global_History,
    input  logic                   i_Stall,
    input  logic                   i_Flush,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    output logic                   o_Prediction,
    output logic                   o_Mispredict,
    output logic                   o_Ready
);

    localparam int DEPTH = 1 << BPRED_WIDTH;

    bpred_ctr_t table_q [DEPTH];

    bpred_init_state_t state_q, state_d;
    logic [BPRED_WIDTH-1:0] init_idx_q, init_idx_d;

    logic                   ex_valid_q, ex_valid_d;
    logic [BPRED_WIDTH-1:0] ex_idx_q, ex_idx_d;
    logic                   ex_pred_q, ex_pred_d;

    logic [BPRED_WIDTH-1:0] idx;
    logic                   run;
    logic                   upd_en;
    bpred_ctr_t             upd_ctr;
    bpred_ctr_t             rd_ctr;
    logic                   wr_en;
    logic [BPRED_WIDTH-1:0] wr_idx;
    bpred_ctr_t             wr_ctr;
    logic                   unused_pc;

    assign unused_pc = ^i_DEC_PC;

    assign idx = i_DEC_PC[PC_LSB+BPRED_WIDTH-1:PC_LSB] ^ i_Global_History;
    assign run = (state_q == RUN);
    assign upd_en = run & i_ALU_Branch_Valid & ex_valid_q;

    bpred_sat_counter u_sat (
        .ctr_i   (table_q[ex_idx_q]),
        .taken_i (i_ALU_Branch_Outcome),
        .ctr_o   (upd_ctr)
    );

    always_comb begin
        rd_ctr = table_q[idx];
`ifdef BPRED_BYPASS_EN
        if (upd_en && (ex_idx_q == idx))
            rd_ctr = upd_ctr;
`endif
    end

    assign o_Prediction = run ? rd_ctr[1] : 1'b1;
    assign o_Mispredict = upd_en & (ex_pred_q != i_ALU_Branch_Outcome);
    assign o_Ready      = run;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wr_en      = upd_en;
        wr_idx     = ex_idx_q;
        wr_ctr     = upd_ctr;
        if (!run) begin
            wr_en      = 1'b1;
            wr_idx     = init_idx_q;
            wr_ctr     = CTR_WT;
            init_idx_d = init_idx_q + BPRED_WIDTH'(1);
            if (init_idx_q == '1)
                state_d = RUN;
        end
    end

    // Flush beats stall; nothing enters EX while the table is sweeping.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_idx_d   = ex_idx_q;
        ex_pred_d  = ex_pred_q;
        if (!i_Stall) begin
            ex_valid_d = i_DEC_Is_Branch;
            ex_idx_d   = idx;
            ex_pred_d  = o_Prediction;
        end
        if (i_Flush || !run)
            ex_valid_d = 1'b0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ex_valid_q <= 1'b0;
            ex_idx_q   <= '0;
            ex_pred_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ex_valid_q <= ex_valid_d;
            ex_idx_q   <= ex_idx_d;
            ex_pred_q  <= ex_pred_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_en && !i_Reset)
            table_q[wr_idx] <= wr_ctr;
    end

endmodule

// File: tb/tb_gshare_counter_table.sv
// Directed bench for gshare_counter_table at BPRED_WIDTH=4, PC_LSB=2.
module tb_gshare_counter_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_br;
    logic [31:0] dec_pc;
    logic [3:0] ghr;
    logic       stall;
    logic       flush;
    logic       alu_v;
    logic       alu_o;
    logic       pred;
    logic       mis;
    logic       rdy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gshare_counter_table #(
        .BPRED_WIDTH (4),
        .PC_LSB      (2)
    ) dut (
        .i_Clk                (clk),
        .i_Reset              (rst),
        .i_DEC_Is_Branch      (dec_br),
        .i_DEC_PC             (dec_pc),
        .i_Global_History     (ghr),
        .i_Stall              (stall),
        .i_Flush              (flush),
        .i_ALU_Branch_Valid   (alu_v),
        .i_ALU_Branch_Outcome (alu_o),
        .o_Prediction         (pred),
        .o_Mispredict         (mis),
        .o_Ready              (rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] entry(input int i);
        return 32'(dut.table_q[i]);
    endfunction

    // Put a branch through DEC, then resolve it in EX the next cycle.
    task automatic train(input logic [31:0] pc, input logic taken,
                         input logic exp_mis, input string tag);
        dec_pc = pc;
        ghr    = 4'h0;
        dec_br = 1'b1;
        step();
        dec_br = 1'b0;
        alu_v  = 1'b1;
        alu_o  = taken;
        #1;
        chk(tag, 32'(mis), 32'(exp_mis));
        step();
        alu_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dec_br = 1'b0; dec_pc = '0; ghr = '0;
        stall = 1'b0; flush = 1'b0; alu_v = 1'b0; alu_o = 1'b0;

        step();
        step();
        chk("rst_ready", 32'(rdy), 0);
        chk("rst_pred", 32'(pred), 1);
        chk("rst_mis", 32'(mis), 0);

        rst = 1'b0;
        #1;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("init_ready_c%0d", c), 32'(rdy), 0);
            chk($sformatf("init_pred_c%0d", c), 32'(pred), 1);
            step();
        end
        chk("init_ready_16", 32'(rdy), 1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("init_entry%0d", i), entry(i), 2);

        // idx = 0x5 ^ 0x3 = 6
        dec_pc = 32'h14; ghr = 4'h3;
        #1;
        chk("hash_pred0", 32'(pred), 1);
        dec_br = 1'b1;
        step();
        dec_br = 1'b0; alu_v = 1'b1; alu_o = 1'b0;
        #1;
        chk("hash_mis1", 32'(mis), 1);
        step();
        chk("hash_e6_01", entry(6), 1);
        dec_br = 1'b1;
        step();
        dec_br = 1'b0;
        #1;
        chk("hash_mis2", 32'(mis), 0);
        step();
        alu_v = 1'b0;
        chk("hash_e6_00", entry(6), 0);
        dec_pc = 32'h14; ghr = 4'h3;
        #1;
        chk("hash_pred_nt", 32'(pred), 0);

        for (int k = 0; k < 4; k++)
            train(32'h8, 1'b1, 1'b0, $sformatf("sat_mis%0d", k));
        chk("sat_e2", entry(2), 3);

        dec_pc = 32'h30; ghr = 4'h0; dec_br = 1'b1; stall = 1'b1;
        step(); step(); step();
        stall = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; dec_br = 1'b0; alu_v = 1'b1; alu_o = 1'b0;
        #1;
        chk("flush_mis", 32'(mis), 0);
        step();
        alu_v = 1'b0;
        chk("flush_e12", entry(12), 2);

        train(32'h1C, 1'b0, 1'b1, "coll_prep_mis");
        chk("coll_e7_01", entry(7), 1);
        dec_pc = 32'h1C; ghr = 4'h0; dec_br = 1'b1;
        step();
        alu_v = 1'b1; alu_o = 1'b1;
        #1;
`ifdef BPRED_BYPASS_EN
        chk("coll_pred", 32'(pred), 1);
`else
        chk("coll_pred", 32'(pred), 0);
`endif
        chk("coll_mis", 32'(mis), 1);
        step();
        dec_br = 1'b0; alu_v = 1'b0;
        chk("coll_e7_10", entry(7), 2);
        step();

        train(32'h24, 1'b0, 1'b1, "rr_mis1");
        train(32'h24, 1'b0, 1'b0, "rr_mis2");
        chk("rr_e9_00", entry(9), 0);
        dec_pc = 32'h24; dec_br = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rr_ready0", 32'(rdy), 0);
        chk("rr_exv0", 32'(dut.ex_valid_q), 0);
        for (int c = 0; c < 16; c++)
            step();
        chk("rr_ready1", 32'(rdy), 1);
        chk("rr_e9_10", entry(9), 2);
        chk("rr_exv_end", 32'(dut.ex_valid_q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
